// File: rtl/produto_escalar_pkg.sv
// produto_escalar_pkg: shared FSM state type and length-counter sizing.
package produto_escalar_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/produto_escalar_lane.sv
// produto_escalar_lane: one masked signed/unsigned multiply with a registered product.
module produto_escalar_lane #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_mask,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_prod
);
  logic [2*DATA_W-1:0] a_ext, b_ext, prod_d, prod_q;
  // Extending both operands to the product width gives the correct product in either mode
  always_comb begin
    a_ext  = {{DATA_W{i_signed & i_a[DATA_W-1]}}, i_a};
    b_ext  = {{DATA_W{i_signed & i_b[DATA_W-1]}}, i_b};
    prod_d = (i_en && !i_mask) ? a_ext * b_ext : '0;
  end
  always_ff @(posedge clk) prod_q <= rst ? '0 : prod_d;
  assign o_prod = prod_q;
endmodule

// File: rtl/produto_escalar_stream.sv
// produto_escalar_stream: streaming dot product over LANES pairs per beat,
// two-stage pipeline (lane multiply, then chained lane adds into the accumulator).
module produto_escalar_stream
  import produto_escalar_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 2,
  parameter int MAX_LEN = 256,
  parameter int ACC_W   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [len_w(MAX_LEN)-1:0]   i_len,
  input  logic                        i_signed,
  input  logic                        i_accumulate,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [LANES*DATA_W-1:0]     i_a,
  input  logic [LANES*DATA_W-1:0]     i_b,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ACC_W-1:0]            o_result,
  output logic                        o_overflow
);
  localparam int LEN_W = len_w(MAX_LEN);
  localparam int PW = 2 * DATA_W;
  state_e state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d, len_c;
  logic signed_q, signed_d, ovf_q, ovf_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic accept, last, add_ovf;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d, sum, ext, nxt;
  logic [PW-1:0] prod [LANES];
  logic [LANES-1:0] mask;
  assign accept = state_q == RUN && i_valid;
  assign last   = rem_q <= LEN_W'(LANES);
  assign len_c  = i_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : i_len;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign mask[k] = rem_q <= LEN_W'(k);
    produto_escalar_lane #(.DATA_W(DATA_W)) u_lane (
      .clk(clk), .rst(rst), .i_en(accept), .i_mask(mask[k]), .i_signed(signed_q),
      .i_a(i_a[k*DATA_W +: DATA_W]), .i_b(i_b[k*DATA_W +: DATA_W]), .o_prod(prod[k])
    );
  end
  // Lanes are added one at a time so an overflow inside the lane sum is caught too
  always_comb begin
    sum = acc_q;
    ext = '0;
    nxt = '0;
    add_ovf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      ext = {{(ACC_W-PW){signed_q & prod[k][PW-1]}}, prod[k]};
      nxt = sum + ext;
      add_ovf = add_ovf | (sum[ACC_W-1] == ext[ACC_W-1] && nxt[ACC_W-1] != sum[ACC_W-1]);
      sum = nxt;
    end
  end
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    s1_v_d   = accept;
    s2_v_d   = s1_v_q;
    acc_d    = s1_v_q ? sum : acc_q;
    ovf_d    = ovf_q | (s1_v_q & add_ovf);
    case (state_q)
      IDLE: if (i_start) begin
        rem_d    = len_c;
        signed_d = i_signed;
        acc_d    = i_accumulate ? result_q : '0;
        ovf_d    = 1'b0;
        state_d  = len_c == '0 ? DONE : RUN;
      end
      RUN: if (accept) begin
        rem_d   = last ? '0 : rem_q - LEN_W'(LANES);
        state_d = last ? DRAIN : RUN;
      end
      DRAIN: state_d = (!s1_v_q && !s2_v_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    result_d = state_d == DONE && state_q != DONE ? acc_d : result_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      signed_q <= 1'b0;
      ovf_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      ovf_q    <= ovf_d;
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  assign o_ready    = state_q == RUN;
  assign o_busy     = state_q != IDLE;
  assign o_done     = state_q == DONE;
  assign o_result   = result_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_produto_escalar_stream.sv
// tb_produto_escalar_stream: table-driven dot-product runs plus reset/abort and restart sequences.
module tb_produto_escalar_stream;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_signed = 1'b0, i_accumulate = 1'b0, i_valid = 1'b0;
  logic [8:0] i_len = '0;
  logic [15:0] i_a = '0, i_b = '0;
  logic o_ready, o_busy, o_done, o_overflow;
  logic o_ready16, o_busy16, o_done16, o_overflow16;
  logic [63:0] o_result;
  logic [15:0] o_result16;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  produto_escalar_stream dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_signed(i_signed),
    .i_accumulate(i_accumulate), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_overflow(o_overflow)
  );
  produto_escalar_stream #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_signed(i_signed),
    .i_accumulate(i_accumulate), .i_valid(i_valid), .o_ready(o_ready16), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy16), .o_done(o_done16), .o_result(o_result16), .o_overflow(o_overflow16)
  );

  typedef struct {
    logic [8:0]  len;
    logic        sg, ac;
    logic [63:0] a, b, exp;
    logic        ovf;
    logic [15:0] exp16;
    logic        ovf16;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit gaps, input bit poke);
    int beat, cyc, nb;
    logic [4:0] seq;
    @(negedge clk);
    i_start = 1'b1; i_len = v.len; i_signed = v.sg; i_accumulate = v.ac;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1'b1);
    chk("ovf_cleared", {o_overflow, o_overflow16}, 2'b00);
    if (v.len != 0) begin
      beat = 0; cyc = 0; nb = (int'(v.len) + 1) / 2;
      while (beat < nb && cyc < 200) begin
        @(negedge clk);
        cyc++;
        i_start = poke && cyc == 3;
        i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        i_a = i_valid ? v.a[beat*16 +: 16] : 16'($urandom);
        i_b = i_valid ? v.b[beat*16 +: 16] : 16'($urandom);
        if (i_valid && o_ready) beat++;
      end
      if (beat < nb) begin
        chk("beat_timeout", 64'(beat), 64'(nb));
        return;
      end
      @(negedge clk);
      i_valid = 1'b0;
      chk("ready_low_after_last", o_ready, 1'b0);
    end
    seq[0] = o_done;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      seq[i] = o_done;
    end
    chk("done_timing", seq, v.len == 0 ? 5'b00001 : 5'b01000);
    chk("busy_after_done", o_busy, 1'b0);
    chk("result", o_result, v.exp);
    chk("overflow", o_overflow, v.ovf);
    chk("result16", o_result16, v.exp16);
    chk("overflow16", o_overflow16, v.ovf16);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, cyc;
    logic [7:0] dseen;
    vt[0] = '{9'd8, 1'b0, 1'b0, 64'h0706050403020100, 64'h0102030405060708, 64'd84, 1'b0, 16'd84, 1'b0};
    vt[1] = '{9'd5, 1'b0, 1'b0, 64'h0000640504030201, 64'h0000640101010101, 64'd15, 1'b0, 16'd15, 1'b0};
    vt[2] = '{9'd1, 1'b1, 1'b0, 64'h55FF, 64'h5502, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 16'hFFFE, 1'b0};
    vt[3] = '{9'd1, 1'b0, 1'b0, 64'h55FF, 64'h5502, 64'd510, 1'b0, 16'd510, 1'b0};
    vt[4] = '{9'd8, 1'b0, 1'b0, 64'h0706050403020100, 64'h0102030405060708, 64'd84, 1'b0, 16'd84, 1'b0};
    vt[5] = '{9'd8, 1'b0, 1'b1, 64'h0706050403020100, 64'h0102030405060708, 64'd168, 1'b0, 16'd168, 1'b0};
    vt[6] = '{9'd0, 1'b0, 1'b0, 64'h0, 64'h0, 64'd0, 1'b0, 16'd0, 1'b0};
    vt[7] = '{9'd2, 1'b1, 1'b0, 64'h8080, 64'h8080, 64'd32768, 1'b0, 16'h8000, 1'b1};
    vt[8] = '{9'd1, 1'b0, 1'b0, 64'h03, 64'h04, 64'd12, 1'b0, 16'd12, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_flags", {o_ready, o_busy, o_done, o_overflow}, 4'b0000);
    chk("reset_result", o_result, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run_vec(vt[i], 1'b0, 1'b0);
    // Abort a gappy run after two beats with reset
    @(negedge clk);
    i_start = 1'b1; i_len = 9'd8; i_signed = 1'b0; i_accumulate = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      i_valid = 1'($urandom_range(0, 1));
      i_a = vt[0].a[beat*16 +: 16];
      i_b = vt[0].b[beat*16 +: 16];
      if (i_valid && o_ready) beat++;
    end
    chk("abort_beats", 64'(beat), 64'd2);
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flags", {o_ready, o_busy, o_done, o_overflow}, 4'b0000);
    chk("abort_result", o_result, 64'd0);
    chk("abort_result16", o_result16, 16'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dseen[i] = o_done;
    end
    chk("abort_no_done", dseen, 8'h00);
    run_vec(vt[0], 1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
